leap_cmd_seq: RTL and testbench

Command sequencer directly upstream of the leap datapath stage. Accepts run-length commands (opcode plus repeat count) over a valid/ready handshake, buffers them in a small FIFO, and expands each one into a stream of per-cycle 2-bit `en` opcodes for the leap stage. The leap stage advances its state only on an `en_valid && en_ready` handshake. The block lets benches and formal harnesses drive long, repeatable opcode sequences toward target state values without per-cycle stimulus.

---
 rtl/leap_pkg.sv | 32 +++
 rtl/leap_cmd_fifo.sv | 76 +++++++
 rtl/leap_cmd_seq.sv | 139 +++++++++++++
 tb/tb_leap_cmd_seq.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/leap_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : leap_pkg
//  Description : Shared definitions for the leap command sequencer and the
//                leap datapath: opcode encodings, FSM states, command record.
//  Revision    : 1.0 - initial release
// ============================================================================
package leap_pkg;

  // Opcodes consumed by the leap datapath stage
  localparam logic [1:0] OP_DBL  = 2'b00;  // double
  localparam logic [1:0] OP_HADD = 2'b01;  // add half
  localparam logic [1:0] OP_SUB3 = 2'b10;  // subtract 3
  localparam logic [1:0] OP_ADD3 = 2'b11;  // add 3

  // Default repeat-count width for the command record
  localparam int unsigned LEAP_CNT_W = 8;

  // Sequencer FSM states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } leap_state_t;

  // Run-length command: opcode plus (repeat count - 1)
  typedef struct packed {
    logic [1:0]            op;
    logic [LEAP_CNT_W-1:0] cnt;
  } leap_cmd_t;

endpackage : leap_pkg
`default_nettype wire

// File: rtl/leap_cmd_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : leap_cmd_fifo
//  Description : Parameterised synchronous FIFO with push/pop, full/empty and
//                occupancy count. Read data is the head entry, valid whenever
//                the FIFO is non-empty. DEPTH must be a power of two.
//  Revision    : 1.0 - initial release
// ============================================================================
module leap_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_ok;
  logic             pop_ok;

  // Guard the handshakes so an overflow/underflow can never corrupt state
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i  && !empty_o;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // Next-state for pointers and occupancy; pointers wrap naturally (power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents are don't-care while the slot is not occupied
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

endmodule : leap_cmd_fifo
`default_nettype wire

// File: rtl/leap_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : leap_cmd_seq
//  Description : Command sequencer ahead of the leap datapath. Buffers
//                run-length commands {op, cnt} and expands each into cnt+1
//                per-cycle opcode steps over a valid/ready handshake, with no
//                bubble between consecutive commands.
//  Revision    : 1.0 - initial release
// ============================================================================
module leap_cmd_seq
  import leap_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [1:0]       cmd_op_i,
  input  logic [CNT_W-1:0] cmd_cnt_i,
  output logic             en_valid_o,
  input  logic             en_ready_i,
  output logic [1:0]       en_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [15:0]      steps_o
);

  localparam int unsigned FIFO_W = 2 + CNT_W;
  localparam int unsigned OCC_W  = $clog2(DEPTH) + 1;

  leap_state_t      state_q, state_d;
  logic [1:0]       op_q,    op_d;
  logic [CNT_W-1:0] rem_q,   rem_d;
  logic             done_q,  done_d;
  logic [15:0]      steps_q, steps_d;

  logic              fifo_push;
  logic              fifo_pop;
  logic [FIFO_W-1:0] fifo_wdata;
  logic [FIFO_W-1:0] fifo_rdata;
  logic              fifo_full;
  logic              fifo_empty;
  logic [OCC_W-1:0]  fifo_count;
  logic [1:0]        head_op;
  logic [CNT_W-1:0]  head_cnt;
  logic              step_hs;

  // No pass-through when full: readiness comes only from registered occupancy
  assign cmd_ready_o = !fifo_full;
  assign fifo_push   = cmd_valid_i && cmd_ready_o;
  assign fifo_wdata  = {cmd_op_i, cmd_cnt_i};
  assign head_op     = fifo_rdata[CNT_W +: 2];
  assign head_cnt    = fifo_rdata[CNT_W-1:0];

  assign en_valid_o  = (state_q == ISSUE);
  assign en_o        = op_q;
  assign step_hs     = en_valid_o && en_ready_i;
  assign busy_o      = (fifo_count != '0) || (state_q == ISSUE);
  assign done_o      = done_q;
  assign steps_o     = steps_q;

  leap_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (FIFO_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .data_i  (fifo_wdata),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Sequencer next-state: load, count down, chain the next command or retire
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    done_d   = 1'b0;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = head_op;
          rem_d    = head_cnt;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // Stalled steps leave op and rem untouched
        if (step_hs) begin
          if (rem_q != '0) begin
            rem_d = rem_q - CNT_W'(1);
          end else if (!fifo_empty) begin
            // Chain straight into the next command on the same edge
            fifo_pop = 1'b1;
            op_d     = head_op;
            rem_d    = head_cnt;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Saturating count of accepted steps
  always_comb begin
    steps_d = steps_q;
    if (step_hs && (steps_q != 16'hFFFF)) steps_d = steps_q + 16'd1;
  end

  // Sequencer, done-pulse and step-counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_DBL;
      rem_q   <= '0;
      done_q  <= 1'b0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      steps_q <= steps_d;
    end
  end

endmodule : leap_cmd_seq
`default_nettype wire

// File: tb/tb_leap_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_leap_cmd_seq
//  Description : Self-checking bench for leap_cmd_seq. Accepted commands are
//                expanded into a queue of expected opcodes; each handshaked
//                step pops and compares. Step count and done pulse are
//                modelled every cycle; directed checks cover latency,
//                back-pressure, FIFO full, reset and saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_leap_cmd_seq;
  import leap_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [1:0]  cmd_op_i = 2'b00;
  logic [7:0]  cmd_cnt_i = 8'd0;
  logic        en_valid_o;
  logic        en_ready_i = 1'b0;
  logic [1:0]  en_o;
  logic        busy_o;
  logic        done_o;
  logic [15:0] steps_o;

  leap_cmd_seq #(
    .DEPTH (4),
    .CNT_W (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_op_i    (cmd_op_i),
    .cmd_cnt_i   (cmd_cnt_i),
    .en_valid_o  (en_valid_o),
    .en_ready_i  (en_ready_i),
    .en_o        (en_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .steps_o     (steps_o)
  );

  always #5 clk = ~clk;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [1:0]  q[$];
  logic [15:0] steps_m  = 16'd0;
  logic        exp_done = 1'b0;
  logic        acc;
  int          cyc_n    = 0;
  int          hs_cnt   = 0;
  int          ev_cnt   = 0;
  int          done_cnt = 0;
  int          hs_first = -1;
  int          hs_last  = -1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample and score at negedge, return 1 time unit past posedge
  task automatic cyc();
    logic [1:0] exp_op;
    @(negedge clk);
    acc = 1'b0;
    chk("done", {31'd0, done_o}, {31'd0, exp_done});
    chk("steps", {16'd0, steps_o}, {16'd0, steps_m});
    if (done_o) done_cnt++;
    if (en_valid_o) ev_cnt++;
    if (rst) begin
      q.delete();
      steps_m  = 16'd0;
      exp_done = 1'b0;
    end else begin
      exp_done = 1'b0;
      if (en_valid_o && en_ready_i) begin
        chk("step_expected", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          exp_op = q.pop_front();
          chk("en", {30'd0, en_o}, {30'd0, exp_op});
        end
        if (steps_m != 16'hFFFF) steps_m = steps_m + 16'd1;
        if (q.size() == 0) exp_done = 1'b1;
        hs_cnt++;
        if (hs_first < 0) hs_first = cyc_n;
        hs_last = cyc_n;
      end
      if (cmd_valid_i && cmd_ready_o) begin
        acc = 1'b1;
        for (int i = 0; i <= int'(cmd_cnt_i); i++) q.push_back(cmd_op_i);
      end
    end
    cyc_n++;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] op, input logic [7:0] cnt, input int bound);
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_cnt_i   = cnt;
    for (int i = 0; i < bound; i++) begin
      cyc();
      if (acc) break;
    end
    chk("push_accepted", {31'd0, acc}, 32'd1);
    cmd_valid_i = 1'b0;
  endtask

  task automatic drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (q.size() == 0 && !busy_o && !exp_done) break;
      cyc();
    end
    chk("drain_busy", {31'd0, busy_o}, 32'd0);
    chk("drain_queue", q.size(), 32'd0);
  endtask

  initial begin
    int ev0, dn0, hs0;
    leap_cmd_t c;

    // Reset
    @(posedge clk);
    #1;
    cyc();
    rst = 1'b0;
    chk("rst_en_valid", {31'd0, en_valid_o}, 32'd0);
    chk("rst_en", {30'd0, en_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_done", {31'd0, done_o}, 32'd0);
    chk("rst_steps", {16'd0, steps_o}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);

    // Single command op=00 cnt=3
    en_ready_i = 1'b1;
    ev0 = ev_cnt; dn0 = done_cnt;
    c.op = OP_DBL; c.cnt = 8'd3;
    push(c.op, c.cnt, 10);
    chk("lat_en_valid_e0", {31'd0, en_valid_o}, 32'd0);
    chk("lat_busy_e0", {31'd0, busy_o}, 32'd1);
    cyc();
    chk("lat_en_valid_e1", {31'd0, en_valid_o}, 32'd1);
    chk("lat_en_e1", {30'd0, en_o}, {30'd0, OP_DBL});
    drain(50);
    chk("t1_valid_cycles", ev_cnt - ev0, 32'd4);
    chk("t1_done_pulses", done_cnt - dn0, 32'd1);
    chk("t1_steps", {16'd0, steps_o}, 32'd4);

    // Back-to-back {11,1} then {10,0}: no bubble
    hs0 = hs_cnt; hs_first = -1; hs_last = -1;
    push(OP_ADD3, 8'd1, 10);
    push(OP_SUB3, 8'd0, 10);
    drain(50);
    chk("t2_handshakes", hs_cnt - hs0, 32'd3);
    chk("t2_consecutive", hs_last - hs_first, 32'd2);
    chk("t2_steps", {16'd0, steps_o}, 32'd7);

    // Fill: five commands under back-pressure, sixth must wait
    en_ready_i = 1'b0;
    push(OP_HADD, 8'd0, 10);
    push(OP_SUB3, 8'd0, 10);
    push(OP_ADD3, 8'd0, 10);
    push(OP_DBL,  8'd0, 10);
    push(OP_HADD, 8'd0, 10);
    chk("full_cmd_ready", {31'd0, cmd_ready_o}, 32'd0);
    chk("full_busy", {31'd0, busy_o}, 32'd1);
    chk("full_active_en", {30'd0, en_o}, {30'd0, OP_HADD});
    cmd_valid_i = 1'b1; cmd_op_i = OP_SUB3; cmd_cnt_i = 8'd0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("full_no_accept", {31'd0, acc}, 32'd0);
    end
    en_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (acc) break;
    end
    chk("full_accept_after_free", {31'd0, acc}, 32'd1);
    cmd_valid_i = 1'b0;
    drain(50);
    chk("t3_steps", {16'd0, steps_o}, 32'd13);

    // Stall pattern 1,0,0,1 during op=01 cnt=2
    en_ready_i = 1'b0;
    hs0 = hs_cnt;
    push(OP_HADD, 8'd2, 10);
    for (int i = 0; i < 10; i++) begin
      if (en_valid_o) break;
      cyc();
    end
    chk("t4_valid", {31'd0, en_valid_o}, 32'd1);
    en_ready_i = 1'b1; cyc();
    en_ready_i = 1'b0; cyc();
    chk("t4_stall_valid", {31'd0, en_valid_o}, 32'd1);
    chk("t4_stall_en", {30'd0, en_o}, {30'd0, OP_HADD});
    cyc();
    en_ready_i = 1'b1; cyc();
    drain(50);
    chk("t4_handshakes", hs_cnt - hs0, 32'd3);
    chk("t4_steps", {16'd0, steps_o}, 32'd16);

    // Reset mid-command with two entries queued
    en_ready_i = 1'b0;
    dn0 = done_cnt;
    push(OP_ADD3, 8'd5, 10);
    push(OP_SUB3, 8'd5, 10);
    push(OP_DBL,  8'd5, 10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_en_valid", {31'd0, en_valid_o}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy_o}, 32'd0);
    chk("mid_rst_steps", {16'd0, steps_o}, 32'd0);
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready_o}, 32'd1);
    for (int i = 0; i < 3; i++) cyc();
    chk("mid_rst_no_done", done_cnt - dn0, 32'd0);

    // Saturation: 257 commands of 256 steps each
    en_ready_i = 1'b1;
    dn0 = done_cnt;
    for (int k = 0; k < 257; k++) push(2'(k), 8'd255, 600);
    drain(3000);
    chk("sat_steps", {16'd0, steps_o}, 32'h0000FFFF);
    chk("sat_done_pulses", done_cnt - dn0, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_leap_cmd_seq
`default_nettype wire
